enemy_wave_ctrl: RTL

- Schedules a fixed pool of enemyship instances through game waves: staggered spawn, per-slot respawn timing, kill counting, per-wave quota, inter-wave gap and final-wave win.
- Drives each ship's reset, animate and alive inputs.
- Consumes per-slot hit pulses from the collision logic.
- Sits between the top-level game FSM and the enemy ship array.

---
 rtl/enemy_wave_pkg.sv | 30 +++
 rtl/enemy_slot_timer.sv | 53 +++++
 rtl/enemy_wave_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/enemy_wave_pkg.sv
// Shared types and helpers for the enemy wave scheduler: FSM state encoding,
// slot/gap timer sizing and per-wave kill quota.
package enemy_wave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2,
    ST_WON    = 2'd3
  } wave_state_t;

  // One width serves slot timers and the gap timer: the largest value any of them loads.
  function automatic int tmr_width(input int respawn, input int n_slots,
                                   input int stagger, input int gap);
    int m;
    m = respawn;
    if ((n_slots - 1) * stagger + 1 > m) m = (n_slots - 1) * stagger + 1;
    if (gap > m) m = gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic logic [7:0] quota(input logic [3:0] wave, input int base, input int step);
    logic [7:0] b;
    logic [7:0] s;
    b = base[7:0];
    s = step[7:0];
    return b + s * {4'd0, wave};
  endfunction

endpackage

// File: rtl/enemy_slot_timer.sv
// One enemy slot: dead/alive status, spawn countdown in animation frames,
// one-clock ship reset pulse on spawn and hit acceptance.
module enemy_slot_timer
  import enemy_wave_pkg::*;
#(
  parameter int TW             = 8,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_tick,
  input  logic          i_hit,
  input  logic          i_kill_all,
  output logic          o_rst,
  output logic          o_alive,
  output logic          o_hit_acc
);

  localparam logic [TW-1:0] RESP = TW'(RESPAWN_FRAMES);

  logic [TW-1:0] tmr;

  // Kept independent of i_kill_all: the top derives kill-all from this signal.
  assign o_hit_acc = i_hit & o_alive;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr     <= '0;
      o_rst   <= 1'b0;
      o_alive <= 1'b0;
    end else begin
      o_rst <= 1'b0;
      if (i_load) begin
        tmr     <= i_load_val;
        o_alive <= 1'b0;
      end else if (i_kill_all) begin
        tmr     <= '0;
        o_alive <= 1'b0;
      end else if (o_hit_acc) begin
        tmr     <= RESP;
        o_alive <= 1'b0;
      end else if (o_rst) begin
        o_alive <= 1'b1;
      end else if (!o_alive && i_tick && tmr != '0) begin
        tmr <= tmr - 1'b1;
        if (tmr == TW'(1)) o_rst <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_wave_ctrl.sv
// Wave scheduler for the enemy ship pool: staggered spawns, respawn, kill
// counting against a per-wave quota, inter-wave gap and final-wave win.
module enemy_wave_ctrl
  import enemy_wave_pkg::*;
#(
  parameter int N_SLOTS        = 4,
  parameter int RESPAWN_FRAMES = 120,
  parameter int STAGGER_FRAMES = 30,
  parameter int GAP_FRAMES     = 60,
  parameter int MAX_WAVE       = 7,
  parameter int QUOTA_BASE     = 4,
  parameter int QUOTA_STEP     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_paused,
  input  logic               i_start,
  input  logic [N_SLOTS-1:0] i_hit,
  output logic [N_SLOTS-1:0] o_slot_rst,
  output logic [N_SLOTS-1:0] o_animate,
  output logic [N_SLOTS-1:0] o_alive,
  output logic [3:0]         o_wave,
  output logic [7:0]         o_kills,
  output logic [1:0]         o_state,
  output logic               o_wave_done
);

  localparam int TW = tmr_width(RESPAWN_FRAMES, N_SLOTS, STAGGER_FRAMES, GAP_FRAMES);
  localparam int CW = $clog2(N_SLOTS + 1);

  wave_state_t        state, state_nxt;
  logic               tick, act, load, kill_all, met, gap_adv;
  logic [N_SLOTS-1:0] hit_q, hit_acc;
  logic [CW-1:0]      inc;
  logic [7:0]         q, wave_kills, room, add;
  logic [8:0]         ksum;
  logic [TW-1:0]      gap_tmr;

  assign tick  = i_ani_stb & ~i_paused;
  assign act   = (state == ST_ACTIVE);
  assign hit_q = i_hit & {N_SLOTS{act & ~i_paused}};

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    enemy_slot_timer #(
      .TW             (TW),
      .RESPAWN_FRAMES (RESPAWN_FRAMES)
    ) u_slot (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (load),
      .i_load_val (TW'(k * STAGGER_FRAMES + 1)),
      .i_tick     (tick & act),
      .i_hit      (hit_q[k]),
      .i_kill_all (kill_all),
      .o_rst      (o_slot_rst[k]),
      .o_alive    (o_alive[k]),
      .o_hit_acc  (hit_acc[k])
    );
  end

  always_comb begin
    inc = '0;
    for (int k = 0; k < N_SLOTS; k++) inc = inc + CW'(hit_acc[k]);
  end

  // Increment is clamped to what the quota still has room for; the game total takes the same step.
  assign q    = quota(o_wave, QUOTA_BASE, QUOTA_STEP);
  assign room = q - wave_kills;
  assign met  = act && (8'(inc) >= room);
  assign add  = (8'(inc) >= room) ? room : 8'(inc);
  assign ksum = {1'b0, o_kills} + {1'b0, add};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    kill_all  = 1'b0;
    gap_adv   = 1'b0;
    case (state)
      ST_IDLE: if (i_start) begin
        state_nxt = ST_ACTIVE;
        load      = 1'b1;
      end
      ST_ACTIVE: if (met) begin
        kill_all  = 1'b1;
        state_nxt = (o_wave == 4'(MAX_WAVE)) ? ST_WON : ST_GAP;
      end
      ST_GAP: if (tick && gap_tmr <= TW'(1)) begin
        gap_adv   = 1'b1;
        load      = 1'b1;
        state_nxt = ST_ACTIVE;
      end
      ST_WON:  ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wave      <= '0;
      o_kills     <= '0;
      wave_kills  <= '0;
      gap_tmr     <= '0;
      o_wave_done <= 1'b0;
    end else begin
      o_wave_done <= met;
      if (state == ST_IDLE && i_start) begin
        o_wave     <= '0;
        o_kills    <= '0;
        wave_kills <= '0;
      end else if (act) begin
        wave_kills <= wave_kills + add;
        o_kills    <= ksum[8] ? 8'hFF : ksum[7:0];
      end else if (gap_adv) begin
        o_wave     <= o_wave + 1'b1;
        wave_kills <= '0;
      end
      if (met) gap_tmr <= TW'(GAP_FRAMES);
      else if (state == ST_GAP && tick && gap_tmr != '0) gap_tmr <= gap_tmr - 1'b1;
    end
  end

  assign o_animate = o_alive;
  assign o_state   = state;

endmodule
